// File: rtl/lpc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lpc_pkg
//  Description : Shared encodings for the LPC TPM host: FSM states, START
//                code, cycle-type codes, SYNC codes and the idle LAD value.
//  Revision    : 1.0  initial release
// ============================================================================
package lpc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_START   = 4'd1,
        ST_CYCTYPE = 4'd2,
        ST_ADDR    = 4'd3,
        ST_WDATA   = 4'd4,
        ST_TAR1    = 4'd5,
        ST_SYNC    = 4'd6,
        ST_RDATA   = 4'd7,
        ST_TAR2    = 4'd8,
        ST_ABORT   = 4'd9
    } lpc_state_e;

    localparam logic [3:0] c_START_TPM       = 4'b0101;
    localparam logic [3:0] c_CYC_IO_WRITE    = 4'b0010;
    localparam logic [3:0] c_CYC_IO_READ     = 4'b0000;
    localparam logic [3:0] c_SYNC_READY      = 4'b0000;
    localparam logic [3:0] c_SYNC_SHORT_WAIT = 4'b0101;
    localparam logic [3:0] c_SYNC_LONG_WAIT  = 4'b0110;
    localparam logic [3:0] c_SYNC_ERROR      = 4'b1010;
    localparam logic [3:0] c_LAD_IDLE        = 4'hF;

    // Address nibbles go out most-significant first.
    function automatic logic [3:0] addr_nibble(input logic [15:0] addr,
                                               input logic [1:0]  idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = addr[15:12];
            2'd1:    nib = addr[11:8];
            2'd2:    nib = addr[7:4];
            default: nib = addr[3:0];
        endcase
        return nib;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lpc_tpm_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : lpc_tpm_host_if
//  Description : Request/response handshake between a requester and the
//                LPC TPM host engine.
//  Revision    : 1.0  initial release
// ============================================================================
interface lpc_tpm_host_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;

    // Requester side
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout
    );

    // Host engine side
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout
    );

endinterface
`default_nettype wire

// File: rtl/lpc_tpm_host.sv
`default_nettype none
// ============================================================================
//  Module      : lpc_tpm_host
//  Description : LPC host engine issuing single-byte TPM read/write cycles,
//                with SYNC wait handling, error reporting and timeout abort.
//  Revision    : 1.0  initial release
// ============================================================================
module lpc_tpm_host
    import lpc_pkg::*;
#(
    parameter logic [7:0] SYNC_TIMEOUT = 8'd64
) (
    input  wire             lpc_clk,
    input  wire             reset,
    lpc_tpm_host_if.slave   bus,
    output logic            lpc_frame,
    output logic [3:0]      lpc_ad_out,
    output logic            lpc_ad_oe,
    input  wire  [3:0]      lpc_ad_in
);

    lpc_state_e  state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic [7:0]  tmo_q, tmo_d;

    logic        write_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        err_q;

    logic        rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic        rsp_error_q;
    logic        rsp_timeout_q;

    logic        w_accept;
    logic        w_req_ready;
    logic [8:0]  w_tmo_inc;

    assign w_accept  = (state_q == ST_IDLE) && bus.req_valid;
    // One extra bit so the compare against SYNC_TIMEOUT cannot wrap.
    assign w_tmo_inc = {1'b0, tmo_q} + 9'd1;

    assign bus.req_ready   = w_req_ready;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_error   = rsp_error_q;
    assign bus.rsp_timeout = rsp_timeout_q;

    // FSM state, phase counter and SYNC timeout counter.
    always_ff @(posedge lpc_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= 4'd0;
            tmo_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state: phase counts clocks inside a multi-clock state and
    // restarts at zero on every state change.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 4'd1;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                phase_d = 4'd0;
                tmo_d   = 8'd0;
                if (bus.req_valid) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_CYCTYPE;
                phase_d = 4'd0;
            end
            ST_CYCTYPE: begin
                state_d = ST_ADDR;
                phase_d = 4'd0;
            end
            ST_ADDR: begin
                if (phase_q == 4'd3) begin
                    state_d = write_q ? ST_WDATA : ST_TAR1;
                    phase_d = 4'd0;
                end
            end
            ST_WDATA: begin
                if (phase_q == 4'd1) begin
                    state_d = ST_TAR1;
                    phase_d = 4'd0;
                end
            end
            ST_TAR1: begin
                if (phase_q == 4'd1) begin
                    state_d = ST_SYNC;
                    phase_d = 4'd0;
                    tmo_d   = 8'd0;
                end
            end
            ST_SYNC: begin
                phase_d = 4'd0;
                case (lpc_ad_in)
                    c_SYNC_READY, c_SYNC_ERROR: begin
                        state_d = write_q ? ST_TAR2 : ST_RDATA;
                    end
                    c_SYNC_SHORT_WAIT, c_SYNC_LONG_WAIT: begin
                        tmo_d = 8'd0;
                    end
                    default: begin
                        // Anything unrecognised (including a floating bus)
                        // counts toward the abort threshold.
                        tmo_d = w_tmo_inc[7:0];
                        if (w_tmo_inc >= {1'b0, SYNC_TIMEOUT}) begin
                            state_d = ST_ABORT;
                            tmo_d   = 8'd0;
                        end
                    end
                endcase
            end
            ST_RDATA: begin
                if (phase_q == 4'd1) begin
                    state_d = ST_TAR2;
                    phase_d = 4'd0;
                end
            end
            ST_TAR2: begin
                if (phase_q == 4'd1) begin
                    state_d = ST_IDLE;
                    phase_d = 4'd0;
                end
            end
            ST_ABORT: begin
                if (phase_q == 4'd4) begin
                    state_d = ST_IDLE;
                    phase_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 4'd0;
            end
        endcase
    end

    // LPC pin and request-ready decode from the current state and phase.
    always_comb begin
        lpc_frame   = 1'b1;
        lpc_ad_oe   = 1'b0;
        lpc_ad_out  = c_LAD_IDLE;
        w_req_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_req_ready = 1'b1;
            end
            ST_START: begin
                lpc_frame  = 1'b0;
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = c_START_TPM;
            end
            ST_CYCTYPE: begin
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = write_q ? c_CYC_IO_WRITE : c_CYC_IO_READ;
            end
            ST_ADDR: begin
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = addr_nibble(addr_q, phase_q[1:0]);
            end
            ST_WDATA: begin
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = phase_q[0] ? wdata_q[7:4] : wdata_q[3:0];
            end
            ST_TAR1: begin
                // Drive F for one clock, then release the bus.
                lpc_ad_oe = (phase_q == 4'd0);
            end
            ST_ABORT: begin
                if (phase_q < 4'd4) begin
                    lpc_frame = 1'b0;
                    lpc_ad_oe = 1'b1;
                end
            end
            default: begin
                lpc_frame = 1'b1;
            end
        endcase
    end

    // Request latch, SYNC error flag and read-data capture.
    always_ff @(posedge lpc_clk) begin
        if (reset) begin
            write_q <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            if (w_accept) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                rdata_q <= 8'h00;
                err_q   <= 1'b0;
            end
            if ((state_q == ST_SYNC) && (lpc_ad_in == c_SYNC_ERROR)) begin
                err_q <= 1'b1;
            end
            if (state_q == ST_RDATA) begin
                if (phase_q == 4'd0) begin
                    rdata_q[3:0] <= lpc_ad_in;
                end else begin
                    rdata_q[7:4] <= lpc_ad_in;
                end
            end
        end
    end

    // Response registers: loaded together with the rsp_valid pulse and held
    // until the next completion.
    always_ff @(posedge lpc_clk) begin
        if (reset) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if ((state_q == ST_TAR2) && (phase_q == 4'd0)) begin
                rsp_valid_q   <= 1'b1;
                rsp_rdata_q   <= rdata_q;
                rsp_error_q   <= err_q;
                rsp_timeout_q <= 1'b0;
            end else if ((state_q == ST_ABORT) && (phase_q == 4'd3)) begin
                rsp_valid_q   <= 1'b1;
                rsp_rdata_q   <= 8'h00;
                rsp_error_q   <= 1'b0;
                rsp_timeout_q <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lpc_tpm_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lpc_tpm_host
//  Description : Self-checking bench for lpc_tpm_host: a cycle-list model
//                built from the LPC TPM cycle rules, random and directed
//                transactions, and literal checks on key sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lpc_tpm_host;

    localparam int TMO = 64;

    typedef struct {
        bit         chk_ad;
        bit         frame;
        bit         oe;
        logic [3:0] ad;
        bit         ready;
        bit         rv;
        logic [7:0] rdata;
        bit         err;
        bit         tmo;
    } exp_t;

    typedef struct {
        exp_t       e;
        logic [3:0] ad_in;
    } cyc_t;

    logic       lpc_clk = 1'b0;
    logic       reset;
    logic       lpc_frame;
    logic [3:0] lpc_ad_out;
    logic       lpc_ad_oe;
    logic [3:0] lpc_ad_in;

    lpc_tpm_host_if bus_if ();

    lpc_tpm_host #(.SYNC_TIMEOUT(8'd64)) dut (
        .lpc_clk    (lpc_clk),
        .reset      (reset),
        .bus        (bus_if),
        .lpc_frame  (lpc_frame),
        .lpc_ad_out (lpc_ad_out),
        .lpc_ad_oe  (lpc_ad_oe),
        .lpc_ad_in  (lpc_ad_in)
    );

    always #5 lpc_clk = ~lpc_clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: response values the DUT must currently be holding.
    logic [7:0] h_rdata = 8'h00;
    bit         h_err   = 1'b0;
    bit         h_tmo   = 1'b0;

    exp_t       exp_q[$];
    cyc_t       bld[$];
    logic [3:0] scr_g[$];

    // Observation log for literal checks.
    int         cyc_n    = 0;
    int         start_cyc = 0;
    int         rv_cyc   = 0;
    int         last_gap = 0;
    int         abort_lo = 0;
    logic [3:0] lad_log[$];

    function automatic void chk(input string nm, input logic [15:0] act,
                                input logic [15:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp_v, $time);
        end
    endfunction

    function automatic exp_t mk(input bit fr, input bit oe, input logic [3:0] ad);
        exp_t e;
        e.chk_ad = oe;
        e.frame  = fr;
        e.oe     = oe;
        e.ad     = ad;
        e.ready  = 1'b0;
        e.rv     = 1'b0;
        e.rdata  = h_rdata;
        e.err    = h_err;
        e.tmo    = h_tmo;
        return e;
    endfunction

    function automatic exp_t idle_rec();
        exp_t e;
        e        = mk(1'b1, 1'b0, 4'hF);
        e.chk_ad = 1'b1;
        e.ready  = 1'b1;
        return e;
    endfunction

    function automatic void add(input exp_t e, input logic [3:0] adi);
        cyc_t c;
        c.e     = e;
        c.ad_in = adi;
        bld.push_back(c);
    endfunction

    // Drive one clock: inputs for this cycle plus what the outputs must be.
    task automatic cyc(input exp_t e, input logic [3:0] adi);
        lpc_ad_in = adi;
        exp_q.push_back(e);
        @(posedge lpc_clk);
        #1;
    endtask

    task automatic idle();
        bus_if.req_valid = 1'b0;
        cyc(idle_rec(), 4'($urandom));
    endtask

    // One transaction starting in an IDLE cycle. scr_g is what the
    // peripheral shows on successive SYNC clocks. rst_at >= 0 asserts reset
    // during that clock (counted from START) and ends the transaction there.
    task automatic do_txn(input bit w, input logic [15:0] a, input logic [7:0] wd,
                          input logic [3:0] d0, input logic [3:0] d1, input int rst_at);
        exp_t e;
        int   run;
        int   outcome;
        bus_if.req_valid = 1'b1;
        bus_if.req_write = w;
        bus_if.req_addr  = a;
        bus_if.req_wdata = wd;
        cyc(idle_rec(), 4'($urandom));

        bld.delete();
        add(mk(1'b0, 1'b1, 4'h5), 4'($urandom));
        add(mk(1'b1, 1'b1, w ? 4'h2 : 4'h0), 4'($urandom));
        add(mk(1'b1, 1'b1, a[15:12]), 4'($urandom));
        add(mk(1'b1, 1'b1, a[11:8]), 4'($urandom));
        add(mk(1'b1, 1'b1, a[7:4]), 4'($urandom));
        add(mk(1'b1, 1'b1, a[3:0]), 4'($urandom));
        if (w) begin
            add(mk(1'b1, 1'b1, wd[3:0]), 4'($urandom));
            add(mk(1'b1, 1'b1, wd[7:4]), 4'($urandom));
        end
        add(mk(1'b1, 1'b1, 4'hF), 4'($urandom));
        add(mk(1'b1, 1'b0, 4'hF), 4'($urandom));

        run     = 0;
        outcome = 0;
        foreach (scr_g[i]) begin
            add(mk(1'b1, 1'b0, 4'hF), scr_g[i]);
            if (scr_g[i] == 4'h0) begin
                outcome = 1;
                break;
            end
            if (scr_g[i] == 4'hA) begin
                outcome = 2;
                break;
            end
            if (scr_g[i] == 4'h5 || scr_g[i] == 4'h6) begin
                run = 0;
            end else begin
                run++;
                if (run == TMO) begin
                    outcome = 3;
                    break;
                end
            end
        end

        if (outcome == 3) begin
            repeat (4) add(mk(1'b0, 1'b1, 4'hF), 4'($urandom));
            h_rdata = 8'h00;
            h_err   = 1'b0;
            h_tmo   = 1'b1;
            e       = mk(1'b1, 1'b0, 4'hF);
            e.rv    = 1'b1;
            add(e, 4'($urandom));
        end else begin
            if (!w) begin
                add(mk(1'b1, 1'b0, 4'hF), d0);
                add(mk(1'b1, 1'b0, 4'hF), d1);
            end
            add(mk(1'b1, 1'b0, 4'hF), 4'($urandom));
            h_rdata = w ? 8'h00 : {d1, d0};
            h_err   = (outcome == 2);
            h_tmo   = 1'b0;
            e       = mk(1'b1, 1'b0, 4'hF);
            e.rv    = 1'b1;
            add(e, 4'($urandom));
        end

        for (int i = 0; i < bld.size(); i++) begin
            // Request pins wander while busy; the DUT must ignore them.
            bus_if.req_valid = 1'($urandom);
            bus_if.req_write = 1'($urandom);
            bus_if.req_addr  = 16'($urandom);
            bus_if.req_wdata = 8'($urandom);
            if (i == rst_at) begin
                reset = 1'b1;
                cyc(bld[i].e, bld[i].ad_in);
                reset   = 1'b0;
                h_rdata = 8'h00;
                h_err   = 1'b0;
                h_tmo   = 1'b0;
                return;
            end
            cyc(bld[i].e, bld[i].ad_in);
        end
    endtask

    function automatic logic [3:0] pick_other();
        logic [3:0] v;
        do begin
            v = 4'($urandom);
        end while (v == 4'h0 || v == 4'hA || v == 4'h5 || v == 4'h6);
        return v;
    endfunction

    // Compare DUT outputs against the model every clock, and log events.
    always @(negedge lpc_clk) begin
        exp_t e;
        cyc_n++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("lpc_frame", {15'd0, lpc_frame}, {15'd0, e.frame});
            chk("lpc_ad_oe", {15'd0, lpc_ad_oe}, {15'd0, e.oe});
            if (e.chk_ad) chk("lpc_ad_out", {12'd0, lpc_ad_out}, {12'd0, e.ad});
            chk("req_ready", {15'd0, bus_if.req_ready}, {15'd0, e.ready});
            chk("rsp_valid", {15'd0, bus_if.rsp_valid}, {15'd0, e.rv});
            chk("rsp_rdata", {8'd0, bus_if.rsp_rdata}, {8'd0, e.rdata});
            chk("rsp_error", {15'd0, bus_if.rsp_error}, {15'd0, e.err});
            chk("rsp_timeout", {15'd0, bus_if.rsp_timeout}, {15'd0, e.tmo});
        end
        if (lpc_ad_oe && !lpc_frame && lpc_ad_out == 4'h5) begin
            last_gap  = cyc_n - rv_cyc;
            start_cyc = cyc_n;
            lad_log.delete();
            abort_lo  = 0;
        end
        if (lpc_ad_oe) lad_log.push_back(lpc_ad_out);
        if (!lpc_frame && lpc_ad_out == 4'hF) abort_lo++;
        if (bus_if.rsp_valid) rv_cyc = cyc_n;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_lad [9];
        int         saved_rv;
        int         nw;
        int         gap;
        int         rst_at;
        exp_lad = '{4'h5, 4'h2, 4'h0, 4'h0, 4'h2, 4'h4, 4'h5, 4'hA, 4'hF};

        reset            = 1'b1;
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = 16'h0000;
        bus_if.req_wdata = 8'h00;
        lpc_ad_in        = 4'h0;
        @(posedge lpc_clk);
        #1;
        repeat (2) idle();
        reset = 1'b0;
        repeat (2) idle();

        // Write, immediate ready.
        scr_g = '{4'h0};
        do_txn(1'b1, 16'h0024, 8'hA5, 4'h0, 4'h0, -1);
        chk("wr_lad_count", 16'(lad_log.size()), 16'd9);
        for (int i = 0; i < 9 && i < lad_log.size(); i++)
            chk("wr_lad_nibble", {12'd0, lad_log[i]}, {12'd0, exp_lad[i]});
        chk("wr_latency", 16'(rv_cyc - start_cyc), 16'd12);
        chk("wr_error", {15'd0, bus_if.rsp_error}, 16'd0);
        chk("wr_rdata", {8'd0, bus_if.rsp_rdata}, 16'h0000);
        idle();

        // Read with three short waits.
        scr_g = '{4'h5, 4'h5, 4'h5, 4'h0};
        do_txn(1'b0, 16'h0024, 8'h00, 4'h3, 4'hC, -1);
        chk("rd_rdata", {8'd0, bus_if.rsp_rdata}, 16'h00C3);
        chk("rd_latency", 16'(rv_cyc - start_cyc), 16'd15);
        idle();

        // Read answered with SYNC error.
        scr_g = '{4'hA};
        do_txn(1'b0, 16'h0024, 8'h00, 4'h0, 4'h0, -1);
        chk("err_flag", {15'd0, bus_if.rsp_error}, 16'd1);
        chk("err_rdata", {8'd0, bus_if.rsp_rdata}, 16'h0000);
        chk("err_timeout", {15'd0, bus_if.rsp_timeout}, 16'd0);
        idle();

        // Read with a floating bus: abort after the timeout.
        scr_g.delete();
        repeat (70) scr_g.push_back(4'hF);
        do_txn(1'b0, 16'h0024, 8'h00, 4'h1, 4'h2, -1);
        chk("tmo_abort_frames", 16'(abort_lo), 16'd4);
        chk("tmo_flag", {15'd0, bus_if.rsp_timeout}, 16'd1);
        chk("tmo_rdata", {8'd0, bus_if.rsp_rdata}, 16'h0000);
        idle();

        // Reset during ADDR.
        saved_rv = rv_cyc;
        scr_g = '{4'h0};
        do_txn(1'b0, 16'h1234, 8'h00, 4'h7, 4'h7, 3);
        chk("rst_frame", {15'd0, lpc_frame}, 16'd1);
        chk("rst_oe", {15'd0, lpc_ad_oe}, 16'd0);
        chk("rst_ready", {15'd0, bus_if.req_ready}, 16'd1);
        chk("rst_timeout_clr", {15'd0, bus_if.rsp_timeout}, 16'd0);
        repeat (3) idle();
        chk("rst_no_rsp", 16'(rv_cyc - saved_rv), 16'd0);

        // Back-to-back requests with req_valid held.
        scr_g = '{4'h0};
        do_txn(1'b1, 16'h00F0, 8'h3C, 4'h0, 4'h0, -1);
        do_txn(0, 16'h00F1, 8'h00, 4'h9, 4'h6, -1);
        chk("b2b_gap", 16'(last_gap), 16'd2);
        chk("b2b_rdata", {8'd0, bus_if.rsp_rdata}, 16'h0069);
        idle();

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            scr_g.delete();
            nw = $urandom_range(0, 5);
            for (int k = 0; k < nw; k++) begin
                case ($urandom_range(0, 2))
                    0:       scr_g.push_back(4'h5);
                    1:       scr_g.push_back(4'h6);
                    default: scr_g.push_back(pick_other());
                endcase
            end
            if ($urandom_range(0, 7) == 0) begin
                repeat (70) scr_g.push_back(pick_other());
            end else begin
                scr_g.push_back(($urandom_range(0, 1) == 1) ? 4'hA : 4'h0);
            end
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 14)) : -1;
            do_txn(1'($urandom), 16'($urandom), 8'($urandom), 4'($urandom), 4'($urandom), rst_at);
            gap = $urandom_range(0, 2);
            repeat (gap) idle();
        end
        repeat (2) idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lpc_tpm_host.md
LPC_TPM_HOST -- requirements
Module: lpc_tpm_host

Interface
REQ-001 SHALL have parameter SYNC_TIMEOUT, default 8'd64: consecutive no-response SYNC clocks before abort.
REQ-002 lpc_clk  in  1  sole clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  block in IDLE; request accepted when req_valid & req_ready.
REQ-006 req_write  in  1  1 = TPM write, 0 = TPM read.
REQ-007 req_addr  in  16  TPM register address.
REQ-008 req_wdata  in  8  write data.
REQ-009 rsp_valid  out  1  one-cycle pulse: cycle finished.
REQ-010 rsp_rdata  out  8  read data; 8'h00 for writes.
REQ-011 rsp_error  out  1  peripheral returned SYNC error (4'b1010).
REQ-012 rsp_timeout  out  1  cycle aborted on SYNC timeout.
REQ-013 lpc_frame  out  1  LFRAME#, active low.
REQ-014 lpc_ad_out  out  4  LAD drive value.
REQ-015 lpc_ad_oe  out  1  LAD output enable.
REQ-016 lpc_ad_in  in  4  sampled LAD.

Function
REQ-017 SHALL implement states IDLE, START, CYCTYPE, ADDR, WDATA, TAR1, SYNC, RDATA, TAR2, ABORT.
REQ-018 IDLE: lpc_frame=1, oe=0, ad_out=4'hF, req_ready=1; on accept latch write/addr/wdata and enter START next clock.
REQ-019 START (1 clk): lpc_frame=0, oe=1, ad_out=4'b0101 (TPM start).
REQ-020 CYCTYPE (1 clk): frame=1, ad_out=4'b0010 write, 4'b0000 read.
REQ-021 ADDR (4 clk): addr nibbles [15:12],[11:8],[7:4],[3:0] in that order.
REQ-022 WDATA (writes only, 2 clk): wdata[3:0] then wdata[7:4]; reads skip to TAR1.
REQ-023 TAR1 (2 clk): first clock oe=1, ad_out=4'hF; second clock oe=0.
REQ-024 SYNC: oe=0; sample lpc_ad_in each clock: 4'b0000 ready, 4'b1010 error (set error flag, treat as ready), 4'b0101/4'b0110 wait (timeout counter cleared), any other value increments timeout counter.
REQ-025 On ready/error: reads enter RDATA, writes enter TAR2.
REQ-026 Timeout counter reaching SYNC_TIMEOUT SHALL enter ABORT.
REQ-027 RDATA (2 clk): capture lpc_ad_in as rdata[3:0] then rdata[7:4].
REQ-028 TAR2 (2 clk): oe=0, frame=1; on exit pulse rsp_valid with rdata/error, return IDLE.
REQ-029 ABORT (4 clk): frame=0, oe=1, ad_out=4'hF; then 1 clk frame=1, oe=0, pulse rsp_valid with rsp_timeout=1, rdata=8'h00, return IDLE.
REQ-030 Cycle length without waits: read 12 clocks START to rsp_valid; write 12 clocks.
REQ-031 rsp_rdata/rsp_error/rsp_timeout SHALL hold until next rsp_valid; req_ready=0 in every non-IDLE state, including the rsp_valid clock.
REQ-032 req_valid changes while busy SHALL be ignored; latched request fields are not re-sampled.
REQ-033 lpc_ad_oe SHALL never be 1 in SYNC, RDATA, TAR2 or TAR1 second clock.

Reset
REQ-034 Reset SHALL win over all else, any state: next clock IDLE, lpc_frame=1, oe=0, ad_out=4'hF, rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_timeout=0, counters 0.
REQ-035 Reset mid-cycle SHALL emit no rsp_valid and no abort sequence.

Structure
REQ-036 Shared package lpc_pkg SHALL hold state encodings, START 4'b0101, CYCTYPE codes, SYNC codes (READY, SHORT_WAIT, LONG_WAIT, ERROR).
REQ-037 Single module, no sub-module; one 4-bit phase counter and one 8-bit timeout counter.

Verification
REQ-038 Write addr 16'h0024 data 8'hA5, SYNC 0000 at once -> LAD 5,2,0,0,2,4,5,A,F; rsp_valid 12 clk after START, error=0.
REQ-039 Read addr 16'h0024, peripheral 3x 0101 then 0000, data nibbles 3,C -> rsp_rdata=8'hC3, rsp_valid 15 clk after START.
REQ-040 Read, peripheral 1010 then data 0,0 -> rsp_valid, rsp_error=1, rsp_rdata=8'h00.
REQ-041 Read, LAD floats 4'hF for 64 SYNC clocks -> 4 clk frame=0 with LAD F, then rsp_timeout=1.
REQ-042 reset asserted during ADDR -> next clock frame=1, oe=0, req_ready=1, no rsp_valid.
REQ-043 req_valid held high across two back-to-back requests -> second START exactly 1 clk after first rsp_valid+IDLE.
